// File: rtl/pmem_arbiter_if.sv
// Client-side and pmem-side signal bundle for pmem_arbiter.
// master = the arbiter itself, slave = the clients plus the memory model.
interface pmem_arbiter_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
);
   logic [NUM_CH-1:0]        ch_read;
   logic [NUM_CH-1:0]        ch_write;
   logic [NUM_CH*ADDR_W-1:0] ch_address;
   logic [NUM_CH*LINE_W-1:0] ch_wdata;
   logic [LINE_W-1:0]        ch_rdata;
   logic [NUM_CH-1:0]        ch_resp;
   logic                     pmem_read;
   logic                     pmem_write;
   logic [ADDR_W-1:0]        pmem_address;
   logic [BEAT_W-1:0]        pmem_wdata;
   logic [BEAT_W-1:0]        pmem_rdata;
   logic                     pmem_resp;

   modport master (
      input  ch_read, ch_write, ch_address, ch_wdata, pmem_rdata, pmem_resp,
      output ch_rdata, ch_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
   modport slave (
      output ch_read, ch_write, ch_address, ch_wdata, pmem_rdata, pmem_resp,
      input  ch_rdata, ch_resp, pmem_read, pmem_write, pmem_address, pmem_wdata
   );
endinterface

// File: rtl/pmem_arbiter.sv
// N-channel line arbiter onto a single burst pmem port; one line in flight at a time.
// Define PMEM_ARB_FIXED_PRIO_EN for fixed lowest-index priority instead of round-robin.
module pmem_arbiter #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int BEAT_W = 64
) (
   input logic          clk,
   input logic          rst,
   pmem_arbiter_if.master bus
);
   localparam int BURST_LEN = LINE_W / BEAT_W;
   localparam int CNT_W     = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int OFF_W     = $clog2(LINE_W / 8);

   typedef enum logic [1:0] {IDLE, BUSY_RD, BUSY_WR, DONE} state_e;

   state_e              state_q, state_d;
   logic [CH_W-1:0]     gnt_q, gnt_d;
   logic [CH_W-1:0]     rr_q, rr_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]   line_q, line_d;

   logic [NUM_CH-1:0]   req;
   logic [CH_W-1:0]     pick;
   logic                any_req;
   logic                last_beat;

   assign req       = bus.ch_read | bus.ch_write;
   assign last_beat = (cnt_q == CNT_W'(BURST_LEN - 1));

   // Walk from the rr pointer downwards in priority so the nearest requester wins.
   always_comb begin
      int idx;
      idx     = 0;
      pick    = '0;
      any_req = 1'b0;
      for (int k = NUM_CH - 1; k >= 0; k--) begin
         idx = int'(rr_q) + k;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (req[idx]) begin
            pick    = CH_W'(idx);
            any_req = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      rr_d    = rr_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      line_d  = line_q;
      case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_d   = pick;
               addr_d  = bus.ch_address[pick*ADDR_W +: ADDR_W];
               line_d  = bus.ch_wdata[pick*LINE_W +: LINE_W];
               cnt_d   = '0;
               state_d = bus.ch_write[pick] ? BUSY_WR : BUSY_RD;
            end
         end
         BUSY_RD, BUSY_WR: begin
            if (bus.pmem_resp) begin
               if (state_q == BUSY_RD) line_d[cnt_q*BEAT_W +: BEAT_W] = bus.pmem_rdata;
               if (last_beat) begin
                  cnt_d   = '0;
                  state_d = DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
`ifdef PMEM_ARB_FIXED_PRIO_EN
            rr_d = '0;
`else
            rr_d = (gnt_q == CH_W'(NUM_CH - 1)) ? '0 : gnt_q + 1'b1;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
         addr_q  <= '0;
         line_q  <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         line_q  <= line_d;
      end
   end

   // Pmem strobes decode straight from state so a reset drops them without waiting for an edge.
   assign bus.pmem_read    = (state_q == BUSY_RD);
   assign bus.pmem_write   = (state_q == BUSY_WR);
   assign bus.pmem_address = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
   assign bus.pmem_wdata   = line_q[cnt_q*BEAT_W +: BEAT_W];
   assign bus.ch_rdata     = line_q;
   assign bus.ch_resp      = (state_q == DONE) ? (NUM_CH'(1) << gnt_q) : '0;
endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter: vector table of single transactions plus
// hand-written reset, contention, mid-burst abort and stray-resp sequences.
module tb_pmem_arbiter;
   localparam int NUM_CH = 2;
   localparam int ADDR_W = 32;
   localparam int LINE_W = 256;
   localparam int BEAT_W = 64;
   localparam int BL     = LINE_W / BEAT_W;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pmem_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) bus ();
   pmem_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W)) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   typedef struct {
      int          ch;
      bit          wr;
      logic [31:0] addr;
      logic [255:0] line;
      int          waits;
      bit          stray;
      logic [31:0] exp_addr;
   } vec_t;

   int   n_chk  = 0;
   int   n_fail = 0;
   vec_t tbl[5];

   localparam logic [255:0] L0 = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                  64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
   localparam logic [255:0] L1 = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
                                  64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
   localparam logic [255:0] L2 = {64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210,
                                  64'h0F0F_0F0F_0F0F_0F0F, 64'hF0F0_F0F0_F0F0_F0F0};

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_pmem(output int cyc);
      cyc = 0;
      do begin
         step();
         cyc++;
      end while (!(bus.pmem_read || bus.pmem_write) && cyc < 20);
      if (!(bus.pmem_read || bus.pmem_write)) chk("pmem_req_timeout", 0, 1);
   endtask

   // Zero-or-more wait states before each beat; leaves the DUT in DONE.
   task automatic do_beats(input bit wr, input logic [255:0] line, input int waits,
                           input logic [31:0] exp_addr);
      for (int b = 0; b < BL; b++) begin
         for (int w = 0; w < waits; w++) begin
            bus.pmem_resp = 1'b0;
            if (wr) chk("wdata_hold", bus.pmem_wdata, line[b*BEAT_W +: BEAT_W]);
            step();
         end
         bus.pmem_resp  = 1'b1;
         bus.pmem_rdata = line[b*BEAT_W +: BEAT_W];
         chk("pmem_address", bus.pmem_address, exp_addr);
         if (wr) chk("wdata_beat", bus.pmem_wdata, line[b*BEAT_W +: BEAT_W]);
         step();
      end
      bus.pmem_resp  = 1'b0;
      bus.pmem_rdata = '0;
   endtask

   task automatic run_txn(input vec_t v);
      int cyc;
      bus.ch_read[v.ch]                    = !v.wr;
      bus.ch_write[v.ch]                   = v.wr;
      bus.ch_address[v.ch*ADDR_W +: ADDR_W] = v.addr;
      bus.ch_wdata[v.ch*LINE_W +: LINE_W]   = v.line;
      wait_pmem(cyc);
      chk("latency", cyc, 1);
      chk("op_read", bus.pmem_read, !v.wr);
      chk("op_write", bus.pmem_write, v.wr);
      do_beats(v.wr, v.line, v.waits, v.exp_addr);
      chk("ch_resp", bus.ch_resp, 1 << v.ch);
      chk("done_pmem_idle", {bus.pmem_read, bus.pmem_write}, 0);
      if (!v.wr) chk("ch_rdata", bus.ch_rdata, v.line);
      bus.ch_read[v.ch]  = 1'b0;
      bus.ch_write[v.ch] = 1'b0;
      if (v.stray) begin
         bus.pmem_resp  = 1'b1;
         bus.pmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
      end
      step();
      bus.pmem_resp = 1'b0;
      chk("ch_resp_clear", bus.ch_resp, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int   cyc;
      int   exp_ch[4];
      vec_t mv;

      tbl[0] = '{0, 1'b0, 32'h0000_1234, L0, 0, 1'b0, 32'h0000_1220};
      tbl[1] = '{0, 1'b1, 32'hFFFF_FFFF, L2, 1, 1'b0, 32'hFFFF_FFE0};
      tbl[2] = '{1, 1'b1, 32'h0000_ABCF, L1, 2, 1'b0, 32'h0000_ABC0};
      tbl[3] = '{1, 1'b0, 32'h8000_0020, L2, 0, 1'b1, 32'h8000_0020};
      tbl[4] = '{0, 1'b0, 32'h0000_001F, L1, 3, 1'b0, 32'h0000_0000};

      // Reset with both channels requesting: nothing may leave the block.
      rst            = 1'b1;
      bus.ch_read    = 2'b11;
      bus.ch_write   = '0;
      bus.ch_address = '0;
      bus.ch_wdata   = '0;
      bus.pmem_rdata = '0;
      bus.pmem_resp  = 1'b0;
      step();
      step();
      chk("rst_ch_resp", bus.ch_resp, 0);
      chk("rst_ch_rdata", bus.ch_rdata, 0);
      chk("rst_pmem_rw", {bus.pmem_read, bus.pmem_write}, 0);
      chk("rst_pmem_address", bus.pmem_address, 0);
      rst         = 1'b0;
      bus.ch_read = '0;
      step();
      chk("idle_pmem_rw", {bus.pmem_read, bus.pmem_write}, 0);

      // Stray resp in IDLE must be ignored.
      bus.pmem_resp = 1'b1;
      step();
      bus.pmem_resp = 1'b0;
      chk("stray_idle_rw", {bus.pmem_read, bus.pmem_write}, 0);
      chk("stray_idle_resp", bus.ch_resp, 0);

      for (int i = 0; i < 5; i++) run_txn(tbl[i]);

      // Contention from a clean rr pointer.
      rst = 1'b1;
      step();
      rst = 1'b0;
      bus.ch_address = {32'h0000_0200, 32'h0000_0100};
`ifdef PMEM_ARB_FIXED_PRIO_EN
      exp_ch = '{0, 0, 0, 0};
`else
      exp_ch = '{0, 1, 0, 1};
`endif
      bus.ch_read = 2'b11;
      for (int t = 0; t < 4; t++) begin
         wait_pmem(cyc);
         do_beats(1'b0, L0, 0, (exp_ch[t] == 0) ? 32'h0000_0100 : 32'h0000_0200);
         chk("contend_grant", bus.ch_resp, 1 << exp_ch[t]);
         if (t == 3) bus.ch_read[0] = 1'b0;
      end
      wait_pmem(cyc);
      do_beats(1'b0, L1, 0, 32'h0000_0200);
      chk("contend_ch1_alone", bus.ch_resp, 2'b10);
      chk("contend_ch1_rdata", bus.ch_rdata, L1);
      bus.ch_read = '0;
      step();

      // Reset after two beats of a read aborts silently.
      bus.ch_read[0]              = 1'b1;
      bus.ch_address[0 +: ADDR_W] = 32'h0000_0040;
      wait_pmem(cyc);
      for (int b = 0; b < 2; b++) begin
         bus.pmem_resp  = 1'b1;
         bus.pmem_rdata = L2[b*BEAT_W +: BEAT_W];
         step();
      end
      bus.pmem_resp = 1'b0;
      rst = 1'b1;
      #1;
      chk("abort_pmem_read_async", bus.pmem_read, 0);
      chk("abort_ch_resp", bus.ch_resp, 0);
      step();
      chk("abort_ch_resp_held", bus.ch_resp, 0);
      chk("abort_rdata_clear", bus.ch_rdata, 0);
      rst = 1'b0;
      mv = '{0, 1'b0, 32'h0000_0040, L0, 0, 1'b0, 32'h0000_0040};
      run_txn(mv);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
